// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO burst reader and its output skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 3;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// In-order circular buffer presenting its head entry on a valid/ready stream.
module stream_skid_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 3,
  localparam int CNT_W     = $clog2(SKID_DEPTH + 1),
  localparam int PTR_W     = $clog2(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after an accepted pop).
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage and read port carry no reset; only pointers and count are control.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
    if (do_rd) rd_data <= mem[rptr];
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from sync_fifo and streams it out with a last flag,
// keeping pops in flight so the registered FIFO read costs no throughput.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  rd_state_t             state;
  rd_state_t             state_nxt;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      emitted;
  logic                  in_flight;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic [SKID_CNT_W:0]   outstanding;
  logic                  start_acc;
  logic                  beat;

  assign start_acc   = (state == IDLE) && start;
  assign beat        = m_valid && m_ready;
  assign m_last      = m_valid && (emitted == len_q - LEN_W'(1));
  assign outstanding = {1'b0, buf_cnt} + {{SKID_CNT_W{1'b0}}, in_flight};

  // Issue only from registered state so m_ready never reaches the FIFO pop.
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued < len_q) &&
                      (outstanding < (SKID_CNT_W + 1)'(SKID_DEPTH));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (beat && m_last) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      emitted   <= '0;
      in_flight <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= fifo_rd_en;
      if (start_acc) begin
        len_q   <= len;
        issued  <= '0;
        emitted <= '0;
      end else begin
        if (fifo_rd_en) issued  <= issued + LEN_W'(1);
        if (beat)       emitted <= emitted + LEN_W'(1);
      end
    end
  end

  // FIFO read data lands here the cycle after its pop.
  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (fifo_rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader fed by a sync_fifo; scoreboard queue plus negedge monitor.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy, done, fifo_empty, fifo_rd_en, m_valid, m_last, fifo_full;
  logic          m_ready = 1'b0;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [4:0]    fifo_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) u_fifo (
    .clk(clk), .rst_n(fifo_rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(fifo_full),
    .rd_en(fifo_rd_en), .rd_data(fifo_rd_data), .empty(fifo_empty), .count(fifo_count)
  );

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_i), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  typedef struct {logic [DW-1:0] data; logic last;} beat_t;
  beat_t exp_q[$];
  int    beat_cyc[$];
  int    checks = 0, errors = 0;
  int    beat_cnt = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0, rd_empty_viol = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
  initial begin
    beat_t       e;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, prev_data);
        end
        if (fifo_rd_en) begin
          rd_cnt++;
          if (fifo_empty) rd_empty_viol++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_valid && m_ready) begin
          beat_cnt++;
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.data);
            chk("beat_last", m_last, e.last);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fifo_put(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic exp_push(input logic [DW-1:0] d, input logic last);
    beat_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic start_burst(input int l, output int acc);
    start = 1'b1;
    len_i = LW'(l);
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    for (int i = 0; i < 2000 && done_cnt <= base; i++) tick();
    chk(name, done_cnt > base, 1);
  endtask

  initial begin
    int acc, b, r, bc;

    // 1: reset values
    tick(3);
    rst_n      = 1'b1;
    fifo_rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);

    // 2: full-speed burst of 8
    for (int i = 0; i < 8; i++) fifo_put(DW'(i * 8'h11));
    for (int i = 0; i < 8; i++) exp_push(DW'(i * 8'h11), i == 7);
    m_ready = 1'b1;
    beat_cyc.delete();
    b = done_cnt;
    start_burst(8, acc);
    wait_done(b, "t2_done");
    tick(2);
    chk("t2_done_once", done_cnt, b + 1);
    chk("t2_beats", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      chk("t2_first_lat", beat_cyc[0] - acc, 2);
      chk("t2_consec", beat_cyc[7] - beat_cyc[0], 7);
      chk("t2_done_lat", done_cyc, beat_cyc[7] + 1);
    end
    chk("t2_fifo_cnt", fifo_count, 0);
    chk("t2_drained", exp_q.size(), 0);

    // 3: full FIFO, stall then toggling ready
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) fifo_put(DW'(i));
    chk("t3_full", fifo_full, 1);
    for (int i = 0; i < 16; i++) exp_push(DW'(i), i == 15);
    b = done_cnt;
    start_burst(16, acc);
    tick(10);
    chk("t3_stall_cnt", fifo_count, 13);
    for (int i = 0; i < 300 && done_cnt <= b; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    chk("t3_done", done_cnt > b, 1);
    chk("t3_drained", exp_q.size(), 0);
    m_ready = 1'b1;
    tick(2);

    // 4: FIFO runs dry mid-burst
    fifo_put(8'h40);
    fifo_put(8'h41);
    exp_push(8'h40, 0);
    exp_push(8'h41, 0);
    exp_push(8'hA0, 0);
    exp_push(8'hA1, 1);
    b  = done_cnt;
    bc = beat_cnt;
    start_burst(4, acc);
    tick(6);
    chk("t4_two_beats", beat_cnt - bc, 2);
    for (int i = 0; i < 3; i++) begin
      chk("t4_rd_idle", fifo_rd_en, 0);
      chk("t4_busy", busy, 1);
      tick();
    end
    fifo_put(8'hA0);
    fifo_put(8'hA1);
    wait_done(b, "t4_done");
    chk("t4_drained", exp_q.size(), 0);
    tick(2);

    // 5: zero-length burst, then start while busy
    b  = done_cnt;
    r  = rd_cnt;
    bc = beat_cnt;
    start_burst(0, acc);
    tick(3);
    chk("t5_done_once", done_cnt, b + 1);
    chk("t5_done_cyc", done_cyc, acc);
    chk("t5_no_rd", rd_cnt, r);
    chk("t5_no_beat", beat_cnt, bc);

    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_put(DW'(8'h50 + i));
    for (int i = 0; i < 3; i++) exp_push(DW'(8'h50 + i), i == 2);
    b = done_cnt;
    start_burst(3, acc);
    tick(3);
    chk("t5_busy", busy, 1);
    start = 1'b1;
    len_i = LW'(5);
    tick();
    start   = 1'b0;
    m_ready = 1'b1;
    wait_done(b, "t5_done3");
    tick(2);
    chk("t5_len_kept", fifo_count, 2);
    chk("t5_drained", exp_q.size(), 0);
    exp_push(8'h53, 0);
    exp_push(8'h54, 1);
    b = done_cnt;
    start_burst(2, acc);
    wait_done(b, "t5_drain_done");
    tick(2);
    chk("t5_fifo_empty", fifo_count, 0);

    // 6: reset mid-burst
    for (int i = 0; i < 8; i++) fifo_put(DW'(8'h60 + i));
    for (int i = 0; i < 8; i++) exp_push(DW'(8'h60 + i), i == 7);
    m_ready = 1'b1;
    bc = beat_cnt;
    start_burst(8, acc);
    for (int i = 0; i < 100 && beat_cnt < bc + 3; i++) tick();
    m_ready = 1'b0;
    chk("t6_three_beats", beat_cnt - bc, 3);
    tick(8);
    chk("t6_popped", fifo_count, 2);
    b = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_last", m_last, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("t6_no_done", done_cnt, b);
    exp_push(8'h66, 0);
    exp_push(8'h67, 1);
    m_ready = 1'b1;
    start_burst(2, acc);
    wait_done(b, "t6_done");
    tick(2);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_fifo_empty", fifo_count, 0);

    chk("rd_while_empty", rd_empty_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
